// File: rtl/seq_scan_ctrl.sv
// Serial 5-bit pattern scanner: words are shifted MSB first and matches are counted per frame.
// Optional macro SEQ_SCAN_CNT_SAT_EN: hit_cnt saturates at 255 instead of wrapping.
module seq_scan_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [4:0] pattern,
    input  logic       abort,
    output logic       hit,
    output logic [7:0] hit_cnt,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_shreg;
    logic       r_last;
    logic [2:0] r_idx;
    logic [4:0] r_pat;
    logic [4:0] r_hist;
    logic [2:0] r_seen;
    logic       r_first;
    logic       r_hit;
    logic [7:0] r_hit_cnt;

    logic       w_accept;
    logic       w_bit;
    logic [4:0] w_hist_nxt;
    logic [2:0] w_seen_inc;
    logic       w_match;
    logic [7:0] w_cnt_inc;

    assign in_ready   = (r_state == IDLE) && !abort;
    assign w_accept   = in_valid && in_ready;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == DONE) && !abort;
    assign hit        = r_hit;
    assign hit_cnt    = r_hit_cnt;

    assign w_bit      = r_shreg[7];
    assign w_hist_nxt = {r_hist[3:0], w_bit};
    assign w_seen_inc = (r_seen == 3'd5) ? 3'd5 : r_seen + 3'd1;
    // Seen-count of 4 before this bit means a full 5-bit window including it.
    assign w_match    = (r_state == SHIFT) && (r_seen >= 3'd4) &&
                        (w_hist_nxt == r_pat) && !abort;

`ifdef SEQ_SCAN_CNT_SAT_EN
    assign w_cnt_inc = (r_hit_cnt == 8'hFF) ? 8'hFF : r_hit_cnt + 8'd1;
`else
    assign w_cnt_inc = r_hit_cnt + 8'd1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (r_idx == 3'd0) w_state_nxt = r_last ? DONE : IDLE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shreg   <= '0;
            r_last    <= 1'b0;
            r_idx     <= '0;
            r_pat     <= '0;
            r_hist    <= '0;
            r_seen    <= '0;
            r_first   <= 1'b1;
            r_hit     <= 1'b0;
            r_hit_cnt <= '0;
        end else begin
            r_hit <= w_match;
            if (abort) begin
                r_first <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_shreg <= in_data;
                            r_last  <= in_last;
                            r_idx   <= 3'd7;
                            if (r_first) begin
                                r_pat     <= pattern;
                                r_hit_cnt <= '0;
                                r_hist    <= '0;
                                r_seen    <= '0;
                                r_first   <= 1'b0;
                            end
                        end
                    end
                    SHIFT: begin
                        r_shreg <= {r_shreg[6:0], 1'b0};
                        r_hist  <= w_hist_nxt;
                        r_seen  <= w_seen_inc;
                        r_idx   <= r_idx - 3'd1;
                        if (w_match) r_hit_cnt <= w_cnt_inc;
                    end
                    DONE:    r_first <= 1'b1;
                    default: r_first <= 1'b1;
                endcase
            end
        end
    end

endmodule
